sprite_rom_arbiter: RTL

//  Shares one single-port sprite ROM (index ROM clocked on ~vga_clk) and its palette among NUM_REQ

---
 rtl/sprite_rom_arbiter_pkg.sv | 18 +
 rtl/sprite_rom_arbiter_if.sv | 28 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 33 +++
 rtl/sprite_rom_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared sprite ROM types and widths, common to the draw engines, the ROM
// wrappers and the sprite ROM arbiter.
package sprite_rom_arbiter_pkg;

    localparam int SPRITE_ADDR_W = 14;
    localparam int SPRITE_IDX_W  = 4;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_LOCK  = 16;

    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
    typedef logic [SPRITE_IDX_W-1:0]  pal_idx_t;

    // Modulo-n increment used for the round-robin pointer (wraps n-1 -> 0).
    function automatic int wrap_inc(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus of the sprite ROM arbiter. The slave modport is the
// arbiter itself; the master modport is the draw engines plus the ROM.
interface sprite_rom_arbiter_if
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_IDX_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport slave (
        input  req, lock, addr, rom_q,
        output gnt, rom_address, rvalid, rdata
    );

    modport master (
        output req, lock, addr, rom_q,
        input  gnt, rom_address, rvalid, rdata
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N. Returns the one-hot pick and its index.
module sprite_rom_arbiter_rr_pick #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand;

    // Scan from farthest to nearest offset so the nearest requester wins last.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = PTR_W'((int'(ptr) + off) % N);
            if (req[cand]) begin
                pick       = '0;
                pick[cand] = 1'b1;
                idx        = cand;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among NUM_REQ sprite renderers.
// Round-robin grant with an optional bounded lock for back-to-back row
// fetches; ROM data returns one cycle later tagged with the requester.
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = SPRITE_ADDR_W,
    parameter int DATA_W   = SPRITE_IDX_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    sprite_rom_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;

    logic               lock_path;
    logic [NUM_REQ-1:0] gnt_c;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  rom_addr_c;

    sprite_rom_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req  (bus.req),
        .ptr  (rr_ptr_q),
        .pick (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // Grant selection: a still-locked owner under its budget keeps the ROM,
    // otherwise the round-robin pick; nothing is granted while in reset.
    always_comb begin
        lock_path  = owner_vld_q && bus.req[owner_q] && bus.lock[owner_q]
                     && (lock_cnt_q < CNT_W'(MAX_LOCK));
        gnt_c      = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        if (reset_n) begin
            if (lock_path) begin
                gnt_c[owner_q] = 1'b1;
                gnt_idx        = owner_q;
                gnt_any        = 1'b1;
            end else if (rr_any) begin
                gnt_c   = rr_gnt;
                gnt_idx = rr_idx;
                gnt_any = 1'b1;
            end
        end
        rom_addr_c = addr_hold_q;
        if (gnt_any) begin
            rom_addr_c = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
        end
        if (!reset_n) begin
            rom_addr_c = '0;
        end
    end

    // Next state: rotate pointer past the winner, track lock owner/run
    // length, hold the address and stage the one-cycle read return.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        lock_cnt_d  = lock_cnt_q;
        if (gnt_any) begin
            rr_ptr_d = PTR_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
            if (lock_path) begin
                lock_cnt_d = (lock_cnt_q == CNT_W'(MAX_LOCK)) ? lock_cnt_q
                                                              : lock_cnt_q + CNT_W'(1);
            end else begin
                owner_d     = gnt_idx;
                owner_vld_d = 1'b1;
                lock_cnt_d  = CNT_W'(1);
            end
        end else begin
            owner_d     = '0;
            owner_vld_d = 1'b0;
            lock_cnt_d  = '0;
        end
        addr_hold_d = rom_addr_c;
        rvalid_d    = gnt_c;
        rdata_d     = gnt_any ? bus.rom_q : rdata_q;
    end

    // State registers; async reset also discards any in-flight read.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            lock_cnt_q  <= '0;
            addr_hold_q <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            lock_cnt_q  <= lock_cnt_d;
            addr_hold_q <= addr_hold_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.rom_address = rom_addr_c;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;

endmodule
